// File: rtl/aes_round_ops.sv
// aes_round_ops -- shared AES-128 round-operation unit.
//
// Combines an AddRoundKey XOR, the 128-bit state register, a saturating
// 0..10 round counter and an InvMixColumns transform of the registered state.
//
// Ports:
//   CLK        in   1    system clock, all updates on rising edge
//   reset      in   1    synchronous active-high reset, clears all registers
//   LOAD       in   1    start of block: Count <= 0, state_q <= ark_out
//   ENB        in   1    round advance: Count++ (saturating), state_q <= ark_out
//   text_in    in   128  state operand for AddRoundKey
//   key_in     in   128  round-key operand for AddRoundKey
//   ark_out    out  128  text_in ^ key_in (combinational)
//   state_q    out  128  registered state
//   imc_out    out  128  InvMixColumns(state_q)
//   Count      out  4    current round index 0..10
//   last_round out  1    Count == 10
//
// Build option:
//   AES_IMC_PIPE_EN  when defined, imc_out is registered (one extra cycle of
//                    latency, synchronous reset to 0, updates every cycle).
//
// Byte order is FIPS-197: byte 0 = bits [127:120], column c = bytes 4c..4c+3.

module aes_round_ops (
  input  logic         CLK,
  input  logic         reset,
  input  logic         LOAD,
  input  logic         ENB,
  input  logic [127:0] text_in,
  input  logic [127:0] key_in,
  output logic [127:0] ark_out,
  output logic [127:0] state_q,
  output logic [127:0] imc_out,
  output logic [3:0]   Count,
  output logic         last_round
);

  localparam logic [3:0] LAST_ROUND = 4'd10;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11B).
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One InvMixColumns column. The 09/0b/0d/0e multiples are composed from a
  // shared x2/x4/x8 chain per input byte rather than four separate multipliers.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    logic [7:0] r0, r1, r2, r3;
    for (int unsigned i = 0; i < 4; i++) begin
      a[i]  = col[31 - 8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    r0 = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    r1 = m9[0] ^ me[1] ^ mb[2] ^ md[3];
    r2 = md[0] ^ m9[1] ^ me[2] ^ mb[3];
    r3 = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    return {r0, r1, r2, r3};
  endfunction

  logic [127:0] imc_comb;

  assign ark_out    = text_in ^ key_in;
  assign last_round = (Count == LAST_ROUND);

  // State register: LOAD and ENB both capture ark_out exactly once.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= '0;
    end else if (LOAD || ENB) begin
      state_q <= ark_out;
    end
  end

  // Round counter: reset > LOAD > ENB, saturating at 10.
  always_ff @(posedge CLK) begin
    if (reset) begin
      Count <= '0;
    end else if (LOAD) begin
      Count <= '0;
    end else if (ENB && (Count < LAST_ROUND)) begin
      Count <= Count + 4'd1;
    end
  end

  always_comb begin
    imc_comb = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      imc_comb[127 - 32*c -: 32] = inv_mix_col(state_q[127 - 32*c -: 32]);
    end
  end

`ifdef AES_IMC_PIPE_EN
  logic [127:0] imc_q;

  always_ff @(posedge CLK) begin
    if (reset) begin
      imc_q <= '0;
    end else begin
      imc_q <= imc_comb;
    end
  end

  assign imc_out = imc_q;
`else
  assign imc_out = imc_comb;
`endif

endmodule

// File: tb/tb_aes_round_ops.sv
// Self-checking bench for aes_round_ops: directed vectors plus randomized
// LOAD/ENB/reset traffic compared against a behavioural reference model.

module tb_aes_round_ops;

  logic         CLK = 1'b0;
  logic         reset;
  logic         LOAD;
  logic         ENB;
  logic [127:0] text_in;
  logic [127:0] key_in;
  logic [127:0] ark_out;
  logic [127:0] state_q;
  logic [127:0] imc_out;
  logic [3:0]   Count;
  logic         last_round;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [127:0] m_state;
  int           m_count;
  logic [127:0] m_imc_pipe;

  aes_round_ops dut (
    .CLK        (CLK),
    .reset      (reset),
    .LOAD       (LOAD),
    .ENB        (ENB),
    .text_in    (text_in),
    .key_in     (key_in),
    .ark_out    (ark_out),
    .state_q    (state_q),
    .imc_out    (imc_out),
    .Count      (Count),
    .last_round (last_round)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Carry-less polynomial product followed by long division by 0x11B.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p ^= (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p ^= (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] ref_imc(input logic [127:0] s);
    logic [7:0]   coef [4];
    logic [7:0]   col  [4];
    logic [7:0]   r;
    logic [127:0] out;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    out = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) col[j] = s[127 - 8*(4*c + j) -: 8];
      for (int i = 0; i < 4; i++) begin
        r = '0;
        for (int j = 0; j < 4; j++) r ^= gf_mul(coef[(j - i + 4) % 4], col[j]);
        out[127 - 8*(4*c + i) -: 8] = r;
      end
    end
    return out;
  endfunction

  function automatic logic [127:0] exp_imc();
`ifdef AES_IMC_PIPE_EN
    return m_imc_pipe;
`else
    return ref_imc(m_state);
`endif
  endfunction

  // Drive one cycle of inputs, advance the model on the edge, check on the
  // following falling edge.
  task automatic step(input logic rst, input logic ld, input logic en,
                      input logic [127:0] t, input logic [127:0] k, input string tag);
    reset = rst; LOAD = ld; ENB = en; text_in = t; key_in = k;
    #1;
    check({tag, ".ark"}, ark_out, t ^ k);
    @(posedge CLK);
    m_imc_pipe = rst ? '0 : ref_imc(m_state);
    if (rst) begin
      m_state = '0; m_count = 0;
    end else begin
      if (ld || en) m_state = t ^ k;
      if (ld) m_count = 0;
      else if (en && m_count < 10) m_count = m_count + 1;
    end
    @(negedge CLK);
    check({tag, ".state"}, state_q, m_state);
    check({tag, ".count"}, 128'(Count), 128'(m_count));
    check({tag, ".last"}, 128'(last_round), 128'(m_count == 10));
    check({tag, ".imc"}, imc_out, exp_imc());
  endtask

  logic [127:0] rt, rk;

  initial begin
    m_state = '0; m_count = 0; m_imc_pipe = '0;
    reset = 1'b1; LOAD = 1'b0; ENB = 1'b0; text_in = '0; key_in = '0;
    @(negedge CLK);
    step(1'b1, 1'b0, 1'b0, '0, '0, "reset0");
    step(1'b1, 1'b0, 1'b0, '0, '0, "reset1");
    check("reset.state_zero", state_q, '0);
    check("reset.imc_zero", imc_out, '0);

    // AddRoundKey vector, then LOAD
    step(1'b0, 1'b1, 1'b0, 128'h00112233445566778899aabbccddeeff,
         128'h000102030405060708090a0b0c0d0e0f, "ark_load");
    check("ark.vec_state", state_q, 128'h00102030405060708090a0b0c0d0e0f0);
    check("ark.vec_count", 128'(Count), 128'd0);

    // InvMixColumns vector
    step(1'b0, 1'b1, 1'b0, 128'h8e4da1bc9fdc589d01010101c6c6c6c6, '0, "imc_load");
`ifdef AES_IMC_PIPE_EN
    step(1'b0, 1'b0, 1'b0, '0, '0, "imc_wait");
`endif
    check("imc.vec", imc_out, 128'hdb135345f20a225c01010101c6c6c6c6);

    // Counter: LOAD then 12 ENB, saturating at 10
    step(1'b0, 1'b1, 1'b0, 128'h1, 128'h2, "cnt_load");
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b0, 1'b1, {$urandom, $urandom, $urandom, $urandom}, '0, "cnt_enb");
      check("cnt.value", 128'(Count), 128'((i < 10) ? i : 10));
      check("cnt.last", 128'(last_round), 128'(i >= 10));
    end

    // Priority: LOAD+ENB at Count 7
    step(1'b0, 1'b1, 1'b0, 128'h5, '0, "pri_load");
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 128'(i + 9), '0, "pri_enb");
    check("pri.count7", 128'(Count), 128'd7);
    step(1'b0, 1'b1, 1'b1, 128'hcafe, 128'h0f0f, "pri_both");
    check("pri.count0", 128'(Count), 128'd0);
    check("pri.state", state_q, 128'hcafe ^ 128'h0f0f);

    // Reset mid-sequence with ENB high
    step(1'b0, 1'b1, 1'b0, 128'h1234, '0, "rst_load");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 128'habcd0 + 128'(i), '0, "rst_enb");
    step(1'b1, 1'b0, 1'b1, 128'hffff, '0, "rst_mid");
    check("rst.count", 128'(Count), 128'd0);
    check("rst.state", state_q, '0);
    check("rst.last", 128'(last_round), 128'd0);
`ifndef AES_IMC_PIPE_EN
    check("rst.imc", imc_out, '0);
`endif

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rt = {$urandom, $urandom, $urandom, $urandom};
      rk = {$urandom, $urandom, $urandom, $urandom};
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) != 0), rt, rk, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: got no finish expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
